// File: rtl/note_mem_arbiter.sv
// Note-memory front end: streams a loader image into a single-port BRAM, then
// arbitrates round-robin single-word reads from NUM_RD requesters.
module note_mem_arbiter #(
  parameter int unsigned NUM_RD = 4,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  input  logic [DATA_W-1:0]        wr_word,
  output logic                     wr_ready,
  input  logic                     reload,
  input  logic [NUM_RD-1:0]        rd_req,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_grant,
  output logic [NUM_RD-1:0]        rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_err,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_we,
  output logic [DATA_W-1:0]        mem_din,
  input  logic [DATA_W-1:0]        mem_dout,
  output logic                     loaded,
  output logic [ADDR_W:0]          note_count,
  output logic                     overflow
);

  localparam int unsigned IDX_W = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] PTR_MAX = '1;

  typedef enum logic [1:0] {LOAD, IDLE, READ, RESP} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   wr_ptr_q;
  logic [IDX_W-1:0]    prio_q;
  logic [NUM_RD-1:0]   gsel_q;
  logic                err_q;
  logic                reload_pend_q;

  logic                wr_ready_q;
  logic [NUM_RD-1:0]   rd_grant_q;
  logic [NUM_RD-1:0]   rd_valid_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                rd_err_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                mem_we_q;
  logic [DATA_W-1:0]   mem_din_q;
  logic                loaded_q;
  logic [CNT_W-1:0]    note_count_q;
  logic                overflow_q;

  logic                gnt_found;
  logic [IDX_W-1:0]    gnt_idx;
  logic [NUM_RD-1:0]   gnt_onehot;
  logic [ADDR_W-1:0]   sel_addr;
  logic [IDX_W-1:0]    prio_next;
  logic                is_end;
  logic                accept;

  assign is_end    = (wr_word[DATA_W-1 -: 3] == 3'b111);
  assign accept    = wr_valid & wr_ready_q;
  assign prio_next = (gnt_idx == IDX_W'(NUM_RD - 1)) ? '0 : gnt_idx + IDX_W'(1);

  // Round-robin pick: first requester at or after prio_q, wrapping.
  always_comb begin
    int unsigned j;
    j          = 0;
    gnt_found  = 1'b0;
    gnt_idx    = '0;
    gnt_onehot = '0;
    sel_addr   = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      j = 32'(prio_q) + k;
      if (j >= NUM_RD) j = j - NUM_RD;
      if (!gnt_found && rd_req[j]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDX_W'(j);
      end
    end
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      if (IDX_W'(i) == gnt_idx) begin
        gnt_onehot[i] = gnt_found;
        sel_addr      = rd_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= LOAD;
      wr_ptr_q      <= '0;
      prio_q        <= '0;
      gsel_q        <= '0;
      err_q         <= 1'b0;
      reload_pend_q <= 1'b0;
      wr_ready_q    <= 1'b0;
      rd_grant_q    <= '0;
      rd_valid_q    <= '0;
      rd_data_q     <= '0;
      rd_err_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_we_q      <= 1'b0;
      mem_din_q     <= '0;
      loaded_q      <= 1'b0;
      note_count_q  <= '0;
      overflow_q    <= 1'b0;
    end else begin
      mem_we_q   <= 1'b0;
      rd_grant_q <= '0;
      rd_valid_q <= '0;
      rd_err_q   <= 1'b0;
      case (state_q)
        LOAD: begin
          wr_ready_q <= 1'b1;
          if (accept) begin
            mem_we_q   <= 1'b1;
            mem_addr_q <= wr_ptr_q;
            mem_din_q  <= wr_word;
            if (is_end) begin
              loaded_q   <= 1'b1;
              wr_ready_q <= 1'b0;
              state_q    <= IDLE;
            end else begin
              note_count_q <= note_count_q + CNT_W'(1);
              // Last cell taken without an end marker: stop, pointer stays.
              if (wr_ptr_q == PTR_MAX) begin
                overflow_q <= 1'b1;
                loaded_q   <= 1'b1;
                wr_ready_q <= 1'b0;
                state_q    <= IDLE;
              end else begin
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
              end
            end
          end
        end
        IDLE: begin
          if (reload || reload_pend_q) begin
            reload_pend_q <= 1'b0;
            loaded_q      <= 1'b0;
            overflow_q    <= 1'b0;
            note_count_q  <= '0;
            wr_ptr_q      <= '0;
            wr_ready_q    <= 1'b1;
            state_q       <= LOAD;
          end else if (gnt_found) begin
            rd_grant_q <= gnt_onehot;
            gsel_q     <= gnt_onehot;
            mem_addr_q <= sel_addr;
            err_q      <= ({1'b0, sel_addr} >= note_count_q);
            prio_q     <= prio_next;
            state_q    <= READ;
          end
        end
        READ: begin
          if (reload) reload_pend_q <= 1'b1;
          state_q <= RESP;
        end
        RESP: begin
          if (reload) reload_pend_q <= 1'b1;
          rd_valid_q <= gsel_q;
          rd_err_q   <= err_q;
          rd_data_q  <= err_q ? '0 : mem_dout;
          state_q    <= IDLE;
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign wr_ready   = wr_ready_q;
  assign rd_grant   = rd_grant_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign rd_err     = rd_err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_din    = mem_din_q;
  assign loaded     = loaded_q;
  assign note_count = note_count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_note_mem_arbiter.sv
// Directed bench for note_mem_arbiter with a behavioural one-cycle BRAM.
module tb_note_mem_arbiter;
  localparam int NR = 4;
  localparam int AW = 12;
  localparam int DW = 32;

  logic             clk, rst_n;
  logic             wr_valid;
  logic [DW-1:0]    wr_word;
  logic             wr_ready;
  logic             reload;
  logic [NR-1:0]    rd_req;
  logic [NR*AW-1:0] rd_addr;
  logic [NR-1:0]    rd_grant, rd_valid;
  logic [DW-1:0]    rd_data;
  logic             rd_err;
  logic [AW-1:0]    mem_addr;
  logic             mem_we;
  logic [DW-1:0]    mem_din;
  logic [DW-1:0]    mem_dout;
  logic             loaded;
  logic [AW:0]      note_count;
  logic             overflow;

  note_mem_arbiter #(.NUM_RD(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_word(wr_word),
    .wr_ready(wr_ready), .reload(reload), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_grant(rd_grant), .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout),
    .loaded(loaded), .note_count(note_count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] bram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) bram[mem_addr] <= mem_din;
    mem_dout <= bram[mem_addr];
  end

  logic [DW-1:0] mdl [0:(1<<AW)-1];
  int exp_count;
  int n_cmp, n_fail;

  typedef struct {
    int          idx;
    logic [11:0] addr;
    logic [31:0] data;
    logic        err;
  } rd_vec_t;
  rd_vec_t tbl [5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output logic [NR-1:0] g);
    bit ok;
    ok = 1'b0;
    g  = '0;
    for (int c = 0; c < 20 && !ok; c++) begin
      tick();
      if (rd_grant != '0) begin
        g  = rd_grant;
        ok = 1'b1;
      end
    end
    if (!ok) chk("grant_timeout", 64'd0, 64'd1);
  endtask

  task automatic load_word(input logic [31:0] w, input int a, input string nm);
    wr_word  = w;
    wr_valid = 1'b1;
    tick();
    chk({nm, "_we"}, 64'(mem_we), 64'd1);
    chk({nm, "_addr"}, 64'(mem_addr), 64'(a));
    chk({nm, "_din"}, 64'(mem_din), 64'(w));
    mdl[a] = w;
  endtask

  function automatic logic [31:0] exp_data(input logic [11:0] a);
    return (int'(a) < exp_count) ? mdl[a] : 32'd0;
  endfunction

  task automatic do_read(input int idx, input logic [11:0] a, input logic [31:0] ed,
                         input logic ee, input string nm);
    logic [NR-1:0] g, eg;
    eg = '0;
    eg[idx] = 1'b1;
    rd_addr[idx*AW +: AW] = a;
    rd_req = eg;
    wait_grant(g);
    rd_req = '0;
    chk({nm, "_grant"}, 64'(g), 64'(eg));
    tick();
    chk({nm, "_early_valid"}, 64'(rd_valid), 64'd0);
    tick();
    chk({nm, "_valid"}, 64'(rd_valid), 64'(eg));
    chk({nm, "_data"}, 64'(rd_data), 64'(ed));
    chk({nm, "_err"}, 64'(rd_err), 64'(ee));
  endtask

  task automatic multi(input logic [NR-1:0] mask, input logic [7:0] order, input int n,
                       input string nm);
    logic [NR-1:0] g, eg;
    logic [11:0] a;
    int e;
    rd_req = mask;
    for (int k = 0; k < n; k++) begin
      e = int'(order[2*k +: 2]);
      eg = '0;
      eg[e] = 1'b1;
      a = rd_addr[e*AW +: AW];
      wait_grant(g);
      rd_req = rd_req & ~g;
      chk($sformatf("%s_grant%0d", nm, k), 64'(g), 64'(eg));
      tick();
      tick();
      chk($sformatf("%s_valid%0d", nm, k), 64'(rd_valid), 64'(eg));
      chk($sformatf("%s_data%0d", nm, k), 64'(rd_data), 64'(exp_data(a)));
    end
    rd_req = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NR-1:0] g;
    n_cmp = 0; n_fail = 0; exp_count = 0;
    rst_n = 1'b0; wr_valid = 1'b0; wr_word = '0; reload = 1'b0;
    rd_req = '0; rd_addr = '0;

    tbl[0] = '{idx: 2, addr: 12'd1, data: 32'h2222_0002, err: 1'b0};
    tbl[1] = '{idx: 0, addr: 12'd5, data: 32'h0,         err: 1'b1};
    tbl[2] = '{idx: 3, addr: 12'd3, data: 32'h0,         err: 1'b1};
    tbl[3] = '{idx: 3, addr: 12'd0, data: 32'h1111_0001, err: 1'b0};
    tbl[4] = '{idx: 1, addr: 12'd2, data: 32'h3333_0003, err: 1'b0};

    #12;
    chk("rst_outputs", {rd_grant, rd_valid, rd_err, mem_we, loaded, overflow, wr_ready},
        64'd0);
    chk("rst_count", 64'(note_count), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("ready_before_edge", 64'(wr_ready), 64'd0);
    tick();
    chk("ready_after_edge", 64'(wr_ready), 64'd1);

    // Three notes then end marker.
    load_word(32'h1111_0001, 0, "ld0");
    load_word(32'h2222_0002, 1, "ld1");
    load_word(32'h3333_0003, 2, "ld2");
    chk("count_pre_end", 64'(note_count), 64'd3);
    load_word(32'hE000_0000, 3, "ldend");
    wr_valid = 1'b0;
    exp_count = 3;
    chk("loaded", 64'(loaded), 64'd1);
    chk("count_end", 64'(note_count), 64'd3);
    chk("ready_idle", 64'(wr_ready), 64'd0);

    rd_addr[0*AW +: AW] = 12'd0;
    rd_addr[1*AW +: AW] = 12'd1;
    rd_addr[2*AW +: AW] = 12'd2;
    rd_addr[3*AW +: AW] = 12'd0;
    multi(4'b1111, 8'b11_10_01_00, 4, "all4");

    for (int v = 0; v < 5; v++)
      do_read(tbl[v].idx, tbl[v].addr, tbl[v].data, tbl[v].err, $sformatf("tbl%0d", v));

    // Last grant was requester 1, so the search now starts at 2.
    rd_addr[0*AW +: AW] = 12'd2;
    rd_addr[1*AW +: AW] = 12'd0;
    rd_addr[3*AW +: AW] = 12'd1;
    multi(4'b1011, 8'b00_01_00_11, 3, "rr");

    // Reload while a read is in flight.
    rd_addr[2*AW +: AW] = 12'd1;
    rd_req = 4'b0100;
    wait_grant(g);
    rd_req = '0;
    chk("rl_grant", 64'(g), 64'b0100);
    reload = 1'b1;
    tick();
    reload = 1'b0;
    chk("rl_early_valid", 64'(rd_valid), 64'd0);
    tick();
    chk("rl_valid", 64'(rd_valid), 64'b0100);
    chk("rl_data", 64'(rd_data), 64'h2222_0002);
    tick();
    chk("rl_ready", 64'(wr_ready), 64'd1);
    chk("rl_loaded", 64'(loaded), 64'd0);
    chk("rl_count", 64'(note_count), 64'd0);

    rd_req = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("load_nogrant%0d", c), 64'(rd_grant), 64'd0);
    end
    rd_req = '0;

    // Fill the whole memory with non-end words.
    for (int i = 0; i < (1 << AW); i++) begin
      wr_word  = 32'(i);
      wr_valid = 1'b1;
      tick();
      mdl[i] = 32'(i);
      if (i == 0) chk("ovf_first_addr", 64'(mem_addr), 64'd0);
      if (i == (1 << AW) - 2) chk("ovf_not_yet", 64'(overflow), 64'd0);
    end
    exp_count = 1 << AW;
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_loaded", 64'(loaded), 64'd1);
    chk("ovf_count", 64'(note_count), 64'd4096);
    chk("ovf_ready", 64'(wr_ready), 64'd0);
    chk("ovf_last_addr", 64'(mem_addr), 64'd4095);
    tick();
    chk("ovf_ignore_wr", 64'(mem_we), 64'd0);
    wr_valid = 1'b0;
    do_read(0, 12'd4095, 32'd4095, 1'b0, "top_cell");

    // Reload and request together in IDLE: reload wins.
    rd_req = 4'b0001;
    reload = 1'b1;
    tick();
    reload = 1'b0;
    rd_req = '0;
    chk("rlreq_nogrant", 64'(rd_grant), 64'd0);
    chk("rlreq_ready", 64'(wr_ready), 64'd1);
    chk("rlreq_state", {loaded, overflow}, 64'd0);
    chk("rlreq_count", 64'(note_count), 64'd0);

    load_word(32'hABCD_0001, 0, "ld1b");
    load_word(32'hFFFF_FFFF, 1, "ldend1b");
    wr_valid = 1'b0;
    exp_count = 1;
    chk("count_one", 64'(note_count), 64'd1);
    do_read(3, 12'd1, 32'd0, 1'b1, "err_at_count");
    do_read(2, 12'd0, 32'hABCD_0001, 1'b0, "one_note");

    // Reset asserted in the cycle after a grant.
    rd_addr[1*AW +: AW] = 12'd0;
    rd_req = 4'b0010;
    wait_grant(g);
    rd_req = '0;
    chk("rst_grant", 64'(g), 64'b0010);
    rst_n = 1'b0;
    #1;
    chk("rstmid_outputs", {rd_grant, rd_valid, rd_err, mem_we, loaded, overflow, wr_ready},
        64'd0);
    chk("rstmid_bus", {mem_addr, note_count}, 64'd0);
    chk("rstmid_data", {rd_data, mem_din}, 64'd0);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk($sformatf("rstmid_novalid%0d", c), 64'(rd_valid), 64'd0);
    end
    rst_n = 1'b1;
    chk("rstrel_ready0", 64'(wr_ready), 64'd0);
    tick();
    chk("rstrel_ready1", 64'(wr_ready), 64'd1);
    chk("rstrel_novalid", 64'(rd_valid), 64'd0);
    tick();
    chk("rstrel_novalid2", 64'(rd_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
